cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 clk  in  1  Sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  Synchronous, active-high reset.
REQ-003 mem_read  in  1  CPU read request; held until mem_resp.
REQ-004 mem_write  in  1  CPU write request; held until mem_resp.
REQ-005 mem_resp  out  1  Request complete, one cycle.
REQ-006 index  in  3  Set index, cache_addr[6:4].
REQ-007 set_one_hit  in  1  Tag match and valid, way one.
REQ-008 set_two_hit  in  1  Tag match and valid, way two.
REQ-009 set_one_valid  in  1  Way-one valid bit at index.
REQ-010 set_two_valid  in  1  Way-two valid bit at index.
REQ-011 set_one_dirty  in  1  Way-one dirty bit at index.
REQ-012 set_two_dirty  in  1  Way-two dirty bit at index.
REQ-013 load_set_one  out  1  Write enable, way one.
REQ-014 load_set_two  out  1  Write enable, way two.
REQ-015 write_type_set_one  out  1  1 = CPU merge (sets dirty); 0 = line fill (clears dirty).
REQ-016 write_type_set_two  out  1  Same encoding as REQ-015, way two.
REQ-017 data_sel  out  1  Line source: 0 = pmem line, 1 = CPU-merged line.
REQ-018 pmem_read  out  1  Physical memory line read.
REQ-019 pmem_write  out  1  Physical memory line write.
REQ-020 pmem_resp  in  1  Physical memory access done.
REQ-021 pmem_addr_sel  out  2  Address source: 00 = CPU line address, 01 = way-one tag + index, 10 = way-two tag + index.
REQ-022 pmem_wdata_sel  out  1  Writeback data source: 0 = way one, 1 = way two.

Function
REQ-023 The FSM SHALL have three states: IDLE, WRITEBACK and ALLOCATE.
REQ-024 LRU SHALL be an 8-entry 1-bit array indexed by index; the entry names the eviction way (0 = one, 1 = two).
REQ-025 Hit rule: when IDLE, a request is active and set_one_hit or set_two_hit is 1, mem_resp SHALL be 1 combinationally in that cycle.
- If both hit bits are 1, way one wins.
REQ-026 Write hit: in the same cycle, load_set_x, write_type_set_x and data_sel SHALL all be 1 for the hit way.
REQ-027 Write priority: if mem_read and mem_write are both 1, the request SHALL be treated as a write.
REQ-028 LRU update on a hit: at the mem_resp edge, LRU[index] SHALL become the way that did not hit.
REQ-029 Victim selection SHALL be, in priority order:
- way one if set_one_valid = 0;
- else way two if set_two_valid = 0;
- else LRU[index].
REQ-030 Miss in IDLE (request active, no hit): at the next edge the victim SHALL be latched into a register and the FSM SHALL go to:
- WRITEBACK if the victim is valid and dirty;
- ALLOCATE otherwise.
REQ-031 WRITEBACK:
- Outputs: pmem_write = 1; pmem_addr_sel = victim tag code; pmem_wdata_sel = latched victim.
- Stay until pmem_resp = 1, then go to ALLOCATE.
REQ-032 ALLOCATE:
- Outputs: pmem_read = 1; pmem_addr_sel = 00.
- In the pmem_resp cycle: load_set_victim = 1, write_type_set_victim = 0, data_sel = 0; then go to IDLE.
REQ-033 After ALLOCATE, the request SHALL resolve as a hit in IDLE one cycle later.
- Minimum read-miss latency (clean victim, pmem_resp immediate) is 3 cycles.
REQ-034 A request withdrawn mid-miss SHALL NOT abort WRITEBACK or ALLOCATE.
REQ-035 pmem_resp SHALL be ignored in IDLE.
REQ-036 Never more than one of pmem_read, pmem_write, load_set_one and load_set_two SHALL be 1, except load_set_x in the ALLOCATE pmem_resp cycle.
REQ-037 Unused outputs SHALL be 0; pmem_addr_sel SHALL default to 00.

Reset
REQ-038 When rst = 1 at an edge, the FSM SHALL go to IDLE, all LRU entries SHALL be cleared to 0 and the victim register SHALL be cleared.
- All outputs are 0 in the following cycle.
REQ-039 Reset in WRITEBACK or ALLOCATE SHALL abandon the access, with no load_set pulse.
- Valid and dirty bits in the cache sets are not touched by this block.

Verification
REQ-040 Read hit, way two, index 5 -> mem_resp = 1 in the same cycle; LRU[5] = 0 afterward; no pmem activity.
REQ-041 Write hit, way one -> load_set_one = write_type_set_one = data_sel = mem_resp = 1 for one cycle.
REQ-042 Read miss, both ways valid, LRU[2] = 1, way two dirty -> WRITEBACK (pmem_addr_sel = 10, pmem_wdata_sel = 1), then ALLOCATE, then load_set_two with write_type 0, then hit with mem_resp.
REQ-043 Miss with set_one_valid = 0 and a 4-cycle pmem_resp delay -> no WRITEBACK; pmem_read held 4 cycles; load_set_one on the response cycle.
REQ-044 rst asserted in the second WRITEBACK cycle -> IDLE next cycle, pmem_write = 0, no load_set pulse, LRU entries all 0.
REQ-045 mem_read and mem_write both 1 on a way-one hit -> write path taken (load_set_one = 1).

Source files
------------

// File: rtl/cache_control_if.sv
// CPU-side, cache-set and physical-memory control signals of the cache controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface cache_control_if;
   logic       mem_read;
   logic       mem_write;
   logic       mem_resp;
   logic [2:0] index;
   logic       set_one_hit;
   logic       set_two_hit;
   logic       set_one_valid;
   logic       set_two_valid;
   logic       set_one_dirty;
   logic       set_two_dirty;
   logic       load_set_one;
   logic       load_set_two;
   logic       write_type_set_one;
   logic       write_type_set_two;
   logic       data_sel;
   logic       pmem_read;
   logic       pmem_write;
   logic       pmem_resp;
   logic [1:0] pmem_addr_sel;
   logic       pmem_wdata_sel;

   modport slave (
      input  mem_read, mem_write, index,
      input  set_one_hit, set_two_hit, set_one_valid, set_two_valid,
      input  set_one_dirty, set_two_dirty, pmem_resp,
      output mem_resp, load_set_one, load_set_two,
      output write_type_set_one, write_type_set_two, data_sel,
      output pmem_read, pmem_write, pmem_addr_sel, pmem_wdata_sel
   );

   modport master (
      output mem_read, mem_write, index,
      output set_one_hit, set_two_hit, set_one_valid, set_two_valid,
      output set_one_dirty, set_two_dirty, pmem_resp,
      input  mem_resp, load_set_one, load_set_two,
      input  write_type_set_one, write_type_set_two, data_sel,
      input  pmem_read, pmem_write, pmem_addr_sel, pmem_wdata_sel
   );
endinterface

// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit handling, LRU victim choice,
// dirty writeback and line allocation from physical memory.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | serve hits combinationally; on a miss latch the victim
// WRITEBACK | write dirty victim line to pmem until pmem_resp
// ALLOCATE  | read line from pmem; fill victim way on pmem_resp
module cache_control (
   input  logic             clk,
   input  logic             rst,
   cache_control_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] lru_q, lru_d;
   logic       victim_q, victim_d;

   logic req, is_write, hit, hit_way, victim_sel, victim_dirty;

   assign req      = bus.mem_read | bus.mem_write;
   assign is_write = bus.mem_write;
   assign hit      = bus.set_one_hit | bus.set_two_hit;
   // way one wins when both ways report a hit
   assign hit_way  = ~bus.set_one_hit;

   always_comb begin
      if (!bus.set_one_valid)      victim_sel = 1'b0;
      else if (!bus.set_two_valid) victim_sel = 1'b1;
      else                         victim_sel = lru_q[bus.index];
   end

   assign victim_dirty = victim_sel ? (bus.set_two_valid & bus.set_two_dirty)
                                    : (bus.set_one_valid & bus.set_one_dirty);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lru_q    <= '0;
         victim_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lru_q    <= lru_d;
         victim_q <= victim_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lru_d    = lru_q;
      victim_d = victim_q;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               lru_d[bus.index] = ~hit_way;
            end else if (req) begin
               victim_d = victim_sel;
               state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: if (bus.pmem_resp) state_d = ALLOCATE;
         ALLOCATE:  if (bus.pmem_resp) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_resp           = 1'b0;
      bus.load_set_one       = 1'b0;
      bus.load_set_two       = 1'b0;
      bus.write_type_set_one = 1'b0;
      bus.write_type_set_two = 1'b0;
      bus.data_sel           = 1'b0;
      bus.pmem_read          = 1'b0;
      bus.pmem_write         = 1'b0;
      bus.pmem_addr_sel      = 2'b00;
      bus.pmem_wdata_sel     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               bus.mem_resp = 1'b1;
               if (is_write) begin
                  bus.data_sel           = 1'b1;
                  bus.load_set_one       = ~hit_way;
                  bus.write_type_set_one = ~hit_way;
                  bus.load_set_two       = hit_way;
                  bus.write_type_set_two = hit_way;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write     = 1'b1;
            bus.pmem_addr_sel  = victim_q ? 2'b10 : 2'b01;
            bus.pmem_wdata_sel = victim_q;
         end
         ALLOCATE: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               bus.load_set_one = ~victim_q;
               bus.load_set_two = victim_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: IDLE vector table, hand-written miss/reset
// sequences, and randomized traffic against a behavioural model.
module tb_cache_control;

   logic clk;
   logic rst;
   cache_control_if bus ();

   cache_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [2:0] idx;
      logic       h1;
      logic       h2;
      logic       v1;
      logic       v2;
      logic       d1;
      logic       d2;
      logic       presp;
   } in_t;

   typedef struct {
      string       name;
      in_t         i;
      logic [10:0] exp;
   } vec_t;

   int passed = 0;
   int total  = 0;

   // behavioural model: ways numbered 1 and 2, phase 0 idle / 1 writeback / 2 allocate
   int m_phase;
   int m_victim;
   int m_lru [8];

   function automatic logic [10:0] mk(input logic resp, l1, l2, w1, w2, ds, pr, pw,
                                      input logic [1:0] as, input logic wd);
      return {resp, l1, l2, w1, w2, ds, pr, pw, as, wd};
   endfunction

   function automatic in_t mkin(input logic rd, wr, input logic [2:0] idx,
                                input logic h1, h2, v1, v2, d1, d2, presp);
      in_t t;
      t.rd = rd; t.wr = wr; t.idx = idx; t.h1 = h1; t.h2 = h2;
      t.v1 = v1; t.v2 = v2; t.d1 = d1; t.d2 = d2; t.presp = presp;
      return t;
   endfunction

   function automatic logic [10:0] outs();
      return {bus.mem_resp, bus.load_set_one, bus.load_set_two,
              bus.write_type_set_one, bus.write_type_set_two, bus.data_sel,
              bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.pmem_wdata_sel};
   endfunction

   task automatic apply(input in_t i);
      bus.mem_read      = i.rd;
      bus.mem_write     = i.wr;
      bus.index         = i.idx;
      bus.set_one_hit   = i.h1;
      bus.set_two_hit   = i.h2;
      bus.set_one_valid = i.v1;
      bus.set_two_valid = i.v2;
      bus.set_one_dirty = i.d1;
      bus.set_two_dirty = i.d2;
      bus.pmem_resp     = i.presp;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [10:0] exp);
      logic [10:0] got;
      got = outs();
      total++;
      if (got !== exp)
         $display("FAIL %s: got %b want %b (resp l1 l2 wt1 wt2 dsel prd pwr asel wsel)",
                  name, got, exp);
      else
         passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [10:0] model_out(input in_t i);
      logic resp, l1, l2, w1, w2, ds, pr, pw, wd;
      logic [1:0] as;
      int way;
      resp = 0; l1 = 0; l2 = 0; w1 = 0; w2 = 0; ds = 0; pr = 0; pw = 0; wd = 0; as = 2'b00;
      if (m_phase == 0) begin
         if ((i.rd || i.wr) && (i.h1 || i.h2)) begin
            way  = i.h1 ? 1 : 2;
            resp = 1;
            if (i.wr) begin
               ds = 1;
               if (way == 1) begin l1 = 1; w1 = 1; end
               else          begin l2 = 1; w2 = 1; end
            end
         end
      end else if (m_phase == 1) begin
         pw = 1;
         as = (m_victim == 1) ? 2'b01 : 2'b10;
         wd = (m_victim == 2);
      end else begin
         pr = 1;
         if (i.presp) begin
            if (m_victim == 1) l1 = 1;
            else               l2 = 1;
         end
      end
      return mk(resp, l1, l2, w1, w2, ds, pr, pw, as, wd);
   endfunction

   task automatic model_step(input in_t i, input logic r);
      int v;
      bit dirty;
      if (r) begin
         m_phase = 0; m_victim = 1;
         for (int k = 0; k < 8; k++) m_lru[k] = 1;
      end else if (m_phase == 0) begin
         if ((i.rd || i.wr) && (i.h1 || i.h2)) begin
            m_lru[i.idx] = i.h1 ? 2 : 1;
         end else if (i.rd || i.wr) begin
            if (!i.v1)      v = 1;
            else if (!i.v2) v = 2;
            else            v = m_lru[i.idx];
            dirty    = (v == 1) ? (i.v1 && i.d1) : (i.v2 && i.d2);
            m_victim = v;
            m_phase  = dirty ? 1 : 2;
         end
      end else if (m_phase == 1) begin
         if (i.presp) m_phase = 2;
      end else begin
         if (i.presp) m_phase = 0;
      end
   endtask

   vec_t vecs [10];
   logic [10:0] zero;
   logic [10:0] resp_only;

   initial begin
      zero      = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      resp_only = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      vecs[0] = '{"rd_hit_one",   mkin(1, 0, 0, 1, 0, 1, 1, 0, 0, 0), resp_only};
      vecs[1] = '{"rd_hit_two",   mkin(1, 0, 5, 0, 1, 1, 1, 0, 0, 0), resp_only};
      vecs[2] = '{"wr_hit_one",   mkin(0, 1, 1, 1, 0, 1, 1, 0, 0, 0), mk(1, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0)};
      vecs[3] = '{"wr_hit_two",   mkin(0, 1, 6, 0, 1, 1, 1, 1, 1, 0), mk(1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0)};
      vecs[4] = '{"wr_hit_both",  mkin(0, 1, 2, 1, 1, 1, 1, 0, 0, 0), mk(1, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0)};
      vecs[5] = '{"rdwr_hit_one", mkin(1, 1, 3, 1, 0, 1, 1, 0, 0, 0), mk(1, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0)};
      vecs[6] = '{"rd_miss",      mkin(1, 0, 4, 0, 0, 1, 1, 1, 1, 0), zero};
      vecs[7] = '{"no_req_hit",   mkin(0, 0, 7, 1, 1, 1, 1, 0, 0, 0), zero};
      vecs[8] = '{"idle_presp",   mkin(0, 0, 0, 0, 0, 1, 1, 1, 1, 1), zero};
      vecs[9] = '{"rdwr_hit_two", mkin(1, 1, 0, 0, 1, 1, 1, 0, 0, 1), mk(1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0)};

      // reset held: state pinned to IDLE so each vector is purely combinational
      rst = 1'b1;
      apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      tick();
      chk("reset_outputs", zero);
      foreach (vecs[k]) begin
         apply(vecs[k].i);
         chk(vecs[k].name, vecs[k].exp);
         tick();
      end

      // hit way two at index 5 clears LRU[5]: later dirty miss evicts way one
      do_reset();
      apply(mkin(1, 0, 5, 1, 0, 1, 1, 0, 0, 0));
      chk("lru5_seed_hit_one", resp_only);
      tick();
      apply(mkin(1, 0, 5, 0, 1, 1, 1, 0, 0, 0));
      chk("hit_two_idx5", resp_only);
      tick();
      apply(mkin(1, 0, 5, 0, 0, 1, 1, 1, 1, 0));
      chk("miss_idx5_idle", zero);
      tick();
      chk("lru5_evicts_one", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0));

      // dirty way-two victim at index 2: writeback, allocate, fill, hit
      do_reset();
      apply(mkin(1, 0, 2, 1, 0, 1, 1, 0, 1, 0));
      chk("lru2_seed", resp_only);
      tick();
      apply(mkin(1, 0, 2, 0, 0, 1, 1, 0, 1, 0));
      chk("miss2_idle", zero);
      tick();
      chk("wb_cycle1", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1));
      tick();
      apply(mkin(1, 0, 2, 0, 0, 1, 1, 0, 1, 1));
      chk("wb_resp", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1));
      tick();
      chk("alloc_fill_two", mk(0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 0));
      tick();
      apply(mkin(1, 0, 2, 0, 1, 1, 1, 0, 0, 0));
      chk("post_fill_hit", resp_only);
      tick();

      // invalid way one, 4-cycle pmem latency
      do_reset();
      apply(mkin(1, 0, 3, 0, 0, 0, 1, 1, 1, 0));
      chk("miss3_idle", zero);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("alloc_wait", mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      end
      tick();
      apply(mkin(1, 0, 3, 0, 0, 0, 1, 1, 1, 1));
      chk("alloc_fill_one", mk(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      tick();
      apply(mkin(1, 0, 3, 1, 0, 1, 1, 0, 0, 0));
      chk("post_fill_hit3", resp_only);
      tick();

      // reset in second writeback cycle after setting every LRU entry
      do_reset();
      for (int k = 0; k < 8; k++) begin
         apply(mkin(1, 0, 3'(k), 1, 0, 1, 1, 0, 0, 0));
         chk("lru_set_hit", resp_only);
         tick();
      end
      apply(mkin(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
      tick();
      chk("wb_before_rst", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1));
      tick();
      rst = 1'b1;
      apply(mkin(0, 0, 0, 0, 0, 1, 1, 1, 1, 1));
      chk("wb_second_cycle", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1));
      tick();
      rst = 1'b0;
      apply(mkin(0, 0, 0, 0, 0, 1, 1, 1, 1, 1));
      chk("after_rst_idle", zero);
      tick();
      for (int k = 0; k < 8; k++) begin
         apply(mkin(1, 0, 3'(k), 0, 0, 1, 1, 0, 1, 0));
         tick();
         chk("lru_cleared_alloc", mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0));
         apply(mkin(0, 0, 3'(k), 0, 0, 1, 1, 0, 1, 1));
         chk("withdrawn_fill", mk(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0));
         tick();
      end

      // randomized traffic against the model
      do_reset();
      model_step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      for (int n = 0; n < 3000; n++) begin
         in_t ri;
         logic r;
         ri.rd    = ($urandom_range(0, 9) < 6);
         ri.wr    = ($urandom_range(0, 9) < 4);
         ri.idx   = 3'($urandom_range(0, 7));
         ri.h1    = ($urandom_range(0, 9) < 3);
         ri.h2    = ($urandom_range(0, 9) < 3);
         ri.v1    = ($urandom_range(0, 9) < 8);
         ri.v2    = ($urandom_range(0, 9) < 8);
         ri.d1    = $urandom_range(0, 1) == 1;
         ri.d2    = $urandom_range(0, 1) == 1;
         ri.presp = ($urandom_range(0, 9) < 4);
         r        = ($urandom_range(0, 63) == 0);
         rst = r;
         apply(ri);
         chk("random", model_out(ri));
         model_step(ri, r);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
